// File: rtl/ifu_axil_if.sv
// Bundle of IFU request/response, AXI-lite read channels and the idle write channels
// between the instruction-fetch master and its environment.
interface ifu_axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_err;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        input  req_valid, req_addr, flush, inst_ready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid,
        output req_ready, inst_valid, inst, inst_pc, inst_err,
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready
    );

    modport slave (
        output req_valid, req_addr, flush, inst_ready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid,
        input  req_ready, inst_valid, inst, inst_pc, inst_err,
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready
    );
endinterface

// File: rtl/ifu_axil_master.sv
// Instruction-fetch AXI-lite read master: one outstanding read, flush drops an in-flight
// fetch after it completes on the bus, misaligned PCs are reported without touching the bus.
module ifu_axil_master #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] INST_NOP = 32'h0000_0013
) (
    input logic         clk,
    input logic         rst,
    ifu_axil_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic              unused_s;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= {ADDR_W{1'b0}};
            inst_q    <= INST_NOP;
            inst_pc_q <= {ADDR_W{1'b0}};
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state and capture logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        err_d     = err_q;
        drop_d    = drop_q;
        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (bus.req_valid && !bus.flush) begin
                    pc_d = bus.req_addr;
                    if (bus.req_addr[1:0] == 2'b00) begin
                        state_d = ADDR;
                    end else begin
                        // misaligned PC: report as an errored NOP, no bus read
                        state_d   = HOLD;
                        inst_d    = INST_NOP;
                        inst_pc_d = bus.req_addr;
                        err_d     = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                // the AR beat is never withdrawn; a flush only marks the result for discard
                if (bus.flush) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (bus.arready) begin
                    state_d = DATA;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (bus.rvalid) begin
                    if (drop_q || bus.flush) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d   = HOLD;
                        inst_d    = bus.rdata;
                        inst_pc_d = pc_q;
                        err_d     = (bus.rresp != 2'b00);
                    end
                end else if (bus.flush) begin
                    drop_d = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end
            HOLD: begin
                if (bus.flush || bus.inst_ready) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE) && !bus.flush;
    assign bus.arvalid    = (state_q == ADDR);
    assign bus.araddr     = pc_q;
    assign bus.rready     = (state_q == DATA);
    assign bus.inst_valid = (state_q == HOLD);
    assign bus.inst       = (state_q == HOLD) ? inst_q : INST_NOP;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_err   = (state_q == HOLD) && err_q;

    // Write channels exist only for bus completeness
    assign bus.awaddr  = {ADDR_W{1'b0}};
    assign bus.awvalid = 1'b0;
    assign bus.wdata   = {DATA_W{1'b0}};
    assign bus.wstrb   = {(DATA_W/8){1'b0}};
    assign bus.wvalid  = 1'b0;
    assign bus.bready  = 1'b0;
    assign unused_s    = ^{bus.awready, bus.wready, bus.bresp, bus.bvalid};

endmodule

// File: tb/tb_ifu_axil_master.sv
// Bench for ifu_axil_master: directed latency/stall/flush/error/reset scenarios, then random
// traffic against a reference model and a behavioural AXI-lite slave.
module tb_ifu_axil_master;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_axil_if bus ();

    ifu_axil_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   delivered = 0;
    exp_t sb_q[$];

    bit          sl_fixed = 1'b1;
    bit          sl_pend  = 1'b0;
    logic [31:0] sl_addr  = 32'd0;
    int          ar_stall = 0;
    int          r_stall  = 0;

    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    // Instruction memory contents seen by the slave
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        else if (a == 32'h8000_0008) return 32'hDEAD_BEEF;
        else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [1:0] resp_fn(input logic [31:0] a);
        if (a[5:2] == 4'hF) return 2'b10;
        else if (a[5:2] == 4'h7) return 2'b11;
        else return 2'b00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        smp();
        chk("issue_req_ready", 32'(bus.req_ready), 32'd1);
        cyc();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_inst(input string nm);
        int n = 0;
        while (!bus.inst_valid && n < 40) begin
            cyc();
            n++;
        end
        chk({nm, "_inst_valid"}, 32'(bus.inst_valid), 32'd1);
    endtask

    task automatic deliver();
        bus.inst_ready = 1'b1;
        cyc();
        bus.inst_ready = 1'b0;
    endtask

    // Behavioural AXI-lite read slave
    initial begin
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'd0;
        bus.rresp   = 2'b00;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bresp   = 2'b00;
        bus.bvalid  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ar_stall > 0) bus.arready = 1'b0;
            else bus.arready = sl_fixed ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (!sl_pend) bus.rvalid = 1'b0;
            else if (!bus.rvalid) bus.rvalid = (r_stall == 0) && (sl_fixed || $urandom_range(0, 2) == 0);
            bus.rdata = bus.rvalid ? mem_fn(sl_addr) : $urandom;
            bus.rresp = bus.rvalid ? resp_fn(sl_addr) : 2'($urandom);
            @(negedge clk);
            if (rst) begin
                sl_pend  = 1'b0;
                ar_stall = 0;
                r_stall  = 0;
            end else begin
                if (bus.arvalid && bus.arready) begin
                    sl_pend = 1'b1;
                    sl_addr = bus.araddr;
                end else if (bus.arvalid && ar_stall > 0) begin
                    ar_stall--;
                end
                if (bus.rvalid && bus.rready) sl_pend = 1'b0;
                else if (sl_pend && r_stall > 0) r_stall--;
            end
        end
    end

    // Reference model: accepted request pushes its expected instruction, flush/reset discards it
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                e.pc = bus.req_addr;
                if (bus.req_addr[1:0] != 2'b00) begin
                    e.inst = NOP;
                    e.err  = 1'b1;
                end else begin
                    e.inst = mem_fn(bus.req_addr);
                    e.err  = (resp_fn(bus.req_addr) != 2'b00);
                end
                sb_q.push_back(e);
            end
            if (bus.flush && !(bus.inst_valid && bus.inst_ready) && sb_q.size() > 0)
                sb_q.delete();
        end
    end

    // Monitor: compares delivered instructions and bus-protocol invariants
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            chk("write_tieoff", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
            if (!bus.inst_valid) chk("inst_nop_when_invalid", bus.inst, NOP);
            if (prev_wait) begin
                chk("arvalid_held", 32'(bus.arvalid), 32'd1);
                chk("araddr_held", bus.araddr, prev_addr);
            end
            prev_wait = bus.arvalid && !bus.arready;
            prev_addr = bus.araddr;
            if (bus.arvalid && bus.arready) chk("ar_aligned", 32'(bus.araddr[1:0]), 32'd0);
            if (bus.inst_valid && bus.inst_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_inst", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("inst", bus.inst, e.inst);
                    chk("inst_pc", bus.inst_pc, e.pc);
                    chk("inst_err", 32'(bus.inst_err), 32'(e.err));
                    delivered++;
                end
            end
        end
    end

    initial begin
        int          n;
        int          ar_hs;
        int          ar_wait;
        bit          saw_r;
        logic [31:0] hold_inst;
        logic [31:0] r;

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.flush      = 1'b0;
        bus.inst_ready = 1'b0;
        repeat (3) cyc();
        smp();
        chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_rready", 32'(bus.rready), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        chk("rst_inst", bus.inst, NOP);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_inst_err", 32'(bus.inst_err), 32'd0);
        cyc();
        rst = 1'b0;

        // T1 minimum latency, then T3 held instruction
        issue(32'h8000_0000);
        smp();
        chk("t1_arvalid_c1", 32'(bus.arvalid), 32'd1);
        chk("t1_araddr_c1", bus.araddr, 32'h8000_0000);
        cyc();
        smp();
        chk("t1_rready_c2", 32'(bus.rready), 32'd1);
        chk("t1_inst_valid_c2", 32'(bus.inst_valid), 32'd0);
        cyc();
        smp();
        chk("t1_inst_valid_c3", 32'(bus.inst_valid), 32'd1);
        chk("t1_inst_c3", bus.inst, 32'h0010_0093);
        chk("t1_pc_c3", bus.inst_pc, 32'h8000_0000);
        hold_inst = bus.inst;
        repeat (4) begin
            cyc();
            smp();
            chk("t3_inst_stable", bus.inst, hold_inst);
            chk("t3_pc_stable", bus.inst_pc, 32'h8000_0000);
            chk("t3_no_ar", 32'(bus.arvalid), 32'd0);
            chk("t3_req_ready", 32'(bus.req_ready), 32'd0);
        end
        cyc();
        deliver();
        smp();
        chk("t3_req_ready_after", 32'(bus.req_ready), 32'd1);
        cyc();

        // T2 arready stalled five cycles
        ar_stall = 5;
        issue(32'h8000_0040);
        ar_hs   = 0;
        ar_wait = 0;
        n       = 0;
        while (!bus.inst_valid && n < 30) begin
            smp();
            if (bus.arvalid) chk("t2_araddr", bus.araddr, 32'h8000_0040);
            chk("t2_req_ready", 32'(bus.req_ready), 32'd0);
            if (bus.arvalid && bus.arready) ar_hs++;
            if (bus.arvalid && !bus.arready) ar_wait++;
            cyc();
            n++;
        end
        chk("t2_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("t2_ar_handshakes", 32'(ar_hs), 32'd1);
        chk("t2_ar_wait_cycles", 32'(ar_wait), 32'd5);
        deliver();

        // T4 flush while waiting for R
        r_stall = 3;
        issue(32'h8000_0008);
        n = 0;
        while (!bus.rready && n < 20) begin
            cyc();
            n++;
        end
        chk("t4_in_data", 32'(bus.rready), 32'd1);
        bus.flush = 1'b1;
        smp();
        cyc();
        bus.flush = 1'b0;
        saw_r = 1'b0;
        repeat (8) begin
            smp();
            chk("t4_no_inst_valid", 32'(bus.inst_valid), 32'd0);
            if (bus.rvalid && bus.rready) saw_r = 1'b1;
            cyc();
        end
        chk("t4_r_consumed", 32'(saw_r), 32'd1);
        issue(32'h8000_0004);
        wait_inst("t4_next");
        deliver();

        // T5 slave error response, then misaligned PC
        issue(32'h8000_003C);
        wait_inst("t5_slverr");
        smp();
        chk("t5_slverr_err", 32'(bus.inst_err), 32'd1);
        cyc();
        deliver();
        issue(32'h8000_0002);
        smp();
        chk("t5_mis_no_ar", 32'(bus.arvalid), 32'd0);
        chk("t5_mis_valid", 32'(bus.inst_valid), 32'd1);
        chk("t5_mis_err", 32'(bus.inst_err), 32'd1);
        chk("t5_mis_inst", bus.inst, NOP);
        cyc();
        deliver();

        // T6 reset while AR pending
        ar_stall = 4;
        issue(32'h8000_0010);
        smp();
        chk("t6_in_addr", 32'(bus.arvalid), 32'd1);
        cyc();
        rst = 1'b1;
        smp();
        cyc();
        rst = 1'b0;
        smp();
        chk("t6_arvalid", 32'(bus.arvalid), 32'd0);
        chk("t6_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
        cyc();

        // Random traffic
        sl_fixed = 1'b0;
        n = delivered;
        for (int i = 0; i < 3000; i++) begin
            bus.req_valid  = ($urandom_range(0, 1) == 1);
            r              = $urandom;
            if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(1, 3));
            else r[1:0] = 2'b00;
            bus.req_addr   = r;
            bus.inst_ready = ($urandom_range(0, 1) == 1);
            bus.flush      = !bus.inst_ready && ($urandom_range(0, 19) == 0);
            cyc();
        end
        bus.req_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (60) cyc();
        smp();
        chk("drain_scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("random_made_progress", 32'(delivered > n + 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
